mult_result_queue: RTL and testbench

Downstream collector for the 4-stage pipelined 32x16 multiplier.
- Tags each issued multiply with its destination register and carries the tag down a delay line that matches the multiplier latency.
- Pairs each tag with data_result/exception when result_RDY fires and buffers the pair in a FIFO for the writeback port, which may stall.
- The multiplier cannot stall, so the block enforces credit-based issue: nothing is issued unless a FIFO slot is guaranteed.

---
 rtl/mult_result_queue.sv | 166 ++++++++++++++++
 tb/tb_mult_result_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_queue.sv
// mult_result_queue: collects results from the 4-stage pipelined 32x16
// multiplier and buffers them for a writeback port that may stall.
// Each issued multiply is tagged with its destination register. The tag
// travels down a delay line that matches the multiplier latency, so it
// reaches the end of the line in the same cycle as result_RDY.
// Issue is credit-based because the multiplier cannot stall: a multiply is
// only issued when a FIFO slot is guaranteed for its result.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   issue_valid/issue_tag        issued multiply and its destination tag
//   issue_allowed                a new issue is guaranteed a FIFO slot (comb)
//   mult_result/_exception/_RDY  multiplier output port
//   wb_valid/data/tag/exception  FIFO head, driven combinationally
//   wb_ready                     consumer accepts the head this cycle
//   err_overflow, err_orphan     sticky protocol error flags
module mult_result_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned LATENCY = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_allowed,
  input  logic [31:0]      mult_result,
  input  logic             mult_exception,
  input  logic             mult_result_RDY,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_exception,
  input  logic             wb_ready,
  output logic             err_overflow,
  output logic             err_orphan
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PTR_W  = AW + 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + LATENCY + 1);
  localparam int unsigned MASK_W = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [31:0]      data;
    logic             exc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t             mem_q      [DEPTH];
  entry_t             mem_d      [DEPTH];
  logic               dl_valid_q [LATENCY];
  logic               dl_valid_d [LATENCY];
  logic [TAG_W-1:0]   dl_tag_q   [LATENCY];
  logic [TAG_W-1:0]   dl_tag_d   [LATENCY];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [MASK_W-1:0]  mask_q, mask_d;
  logic               err_overflow_q, err_overflow_d;
  logic               err_orphan_q, err_orphan_d;

  logic               full_c, empty_c, pop_c, push_req_c, last_valid_c;
  logic [CNT_W-1:0]   credits_c;

  // FIFO status from wrap-bit pointers
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Head entry presented combinationally; zeroed when empty
  always_comb begin
    wb_valid     = !empty_c;
    wb_data      = '0;
    wb_tag       = '0;
    wb_exception = 1'b0;
    if (!empty_c) begin
      wb_data      = mem_q[rd_ptr_q[AW-1:0]].data;
      wb_tag       = mem_q[rd_ptr_q[AW-1:0]].tag;
      wb_exception = mem_q[rd_ptr_q[AW-1:0]].exc;
    end
  end

  // Credits: buffered entries plus multiplies still in the pipeline
  always_comb begin
    credits_c = CNT_W'(PTR_W'(wr_ptr_q - rd_ptr_q));
    for (int i = 0; i < int'(LATENCY); i++) begin
      credits_c = credits_c + CNT_W'(dl_valid_q[i]);
    end
    issue_allowed = (credits_c < CNT_W'(DEPTH));
  end

  assign err_overflow = err_overflow_q;
  assign err_orphan   = err_orphan_q;

  // Next-state: delay line, FIFO pointers/storage, orphan mask, error flags
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    mask_d         = mask_q;
    err_overflow_d = err_overflow_q;
    err_orphan_d   = err_orphan_q;

    dl_valid_d[0] = issue_valid & issue_allowed;
    dl_tag_d[0]   = issue_tag;
    for (int i = 1; i < int'(LATENCY); i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_tag_d[i]   = dl_tag_q[i-1];
    end

    last_valid_c = dl_valid_q[LATENCY-1];
    pop_c        = !empty_c & wb_ready;
    push_req_c   = last_valid_c & mult_result_RDY;

    // A pop on the same edge frees the head, so full+pop still accepts
    if (push_req_c && (!full_c || pop_c)) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{data: mult_result, exc: mult_exception,
                                  tag: dl_tag_q[LATENCY-1]};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Stale multiplier results drain during the mask window after reset
    if (mask_q != '0) begin
      mask_d = mask_q - MASK_W'(1);
    end else if (last_valid_c ^ mult_result_RDY) begin
      err_orphan_d = 1'b1;
    end

    if ((issue_valid && !issue_allowed) || (push_req_c && full_c && !pop_c)) begin
      err_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      mask_q         <= MASK_W'(LATENCY);
      err_overflow_q <= 1'b0;
      err_orphan_q   <= 1'b0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        dl_valid_q[i] <= 1'b0;
        dl_tag_q[i]   <= '0;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      mask_q         <= mask_d;
      err_overflow_q <= err_overflow_d;
      err_orphan_q   <= err_orphan_d;
      for (int i = 0; i < int'(LATENCY); i++) begin
        dl_valid_q[i] <= dl_valid_d[i];
        dl_tag_q[i]   <= dl_tag_d[i];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mult_result_queue.sv
// Scoreboard bench for mult_result_queue. A behavioural 4-stage multiplier
// (no reset, like the real one) replays hand-computed products; expected
// writeback entries are queued at issue and popped by a separate monitor.
module tb_mult_result_queue;

  localparam int unsigned LAT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_tag;
  logic        issue_allowed;
  logic [31:0] mult_result;
  logic        mult_exception;
  logic        mult_result_RDY;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_tag;
  logic        wb_exception;
  logic        wb_ready;
  logic        err_overflow;
  logic        err_orphan;

  logic [31:0] m_res;
  logic        m_exc;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_result_queue #(.DEPTH(4), .TAG_W(5), .LATENCY(LAT)) dut (
    .clock           (clock),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_tag       (issue_tag),
    .issue_allowed   (issue_allowed),
    .mult_result     (mult_result),
    .mult_exception  (mult_exception),
    .mult_result_RDY (mult_result_RDY),
    .wb_valid        (wb_valid),
    .wb_data         (wb_data),
    .wb_tag          (wb_tag),
    .wb_exception    (wb_exception),
    .wb_ready        (wb_ready),
    .err_overflow    (err_overflow),
    .err_orphan      (err_orphan)
  );

  always #5 clock = ~clock;

  // Multiplier pipeline model: issue_valid drives mult_signal, result after LAT edges
  logic        mp_v [LAT] = '{default: 1'b0};
  logic [31:0] mp_r [LAT] = '{default: 32'h0};
  logic        mp_e [LAT] = '{default: 1'b0};

  always @(posedge clock) begin
    mp_v[0] <= issue_valid;
    mp_r[0] <= m_res;
    mp_e[0] <= m_exc;
    for (int i = 1; i < int'(LAT); i++) begin
      mp_v[i] <= mp_v[i-1];
      mp_r[i] <= mp_r[i-1];
      mp_e[i] <= mp_e[i-1];
    end
  end

  assign mult_result_RDY = mp_v[LAT-1];
  assign mult_result     = mp_v[LAT-1] ? mp_r[LAT-1] : 32'h0;
  assign mult_exception  = mp_v[LAT-1] ? mp_e[LAT-1] : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry
  always @(negedge clock) begin
    if (!reset && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got tag %0h expected no entry", wb_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_tag", 32'(wb_tag), 32'(e.tag));
        chk("wb_exception", 32'(wb_exception), 32'(e.exc));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Issue one multiply; track=0 for ones that a later reset will kill
  task automatic issue(input logic [4:0] tag, input logic [31:0] res, input logic exc,
                       input logic exp_ok, input logic track);
    chk("issue_allowed_pre", 32'(issue_allowed), 32'(exp_ok));
    issue_valid = 1'b1;
    issue_tag   = tag;
    m_res       = res;
    m_exc       = exc;
    if (exp_ok && track) sb.push_back('{data: res, tag: tag, exc: exc});
    tick();
  endtask

  task automatic drain();
    int n;
    issue_valid = 1'b0;
    wb_ready    = 1'b1;
    n = 0;
    while ((sb.size() != 0 || wb_valid) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_remaining", 32'(sb.size()), 32'd0);
    chk("drain_wb_valid", 32'(wb_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_tag   = '0;
    m_res       = '0;
    m_exc       = 1'b0;
    wb_ready    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_tag", 32'(wb_tag), 32'd0);
    chk("rst_wb_exception", 32'(wb_exception), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    chk("rst_issue_allowed", 32'(issue_allowed), 32'd1);
    idle(LAT);

    // Single op: 7 * -3 = -21, visible LATENCY+1 edges after issue
    issue(5'd5, 32'hFFFF_FFEB, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("single_not_early", 32'(wb_valid), 32'd0);
    idle(1);
    chk("single_wb_valid", 32'(wb_valid), 32'd1);
    chk("single_wb_data", wb_data, 32'hFFFF_FFEB);
    chk("single_wb_tag", 32'(wb_tag), 32'd5);
    chk("single_err_overflow", 32'(err_overflow), 32'd0);
    chk("single_err_orphan", 32'(err_orphan), 32'd0);
    drain();

    // Back-to-back: 2*3, -2*5, 0*9, 256*256
    issue(5'd1, 32'd6, 1'b0, 1'b1, 1'b1);
    issue(5'd2, 32'hFFFF_FFF6, 1'b0, 1'b1, 1'b1);
    issue(5'd3, 32'd0, 1'b0, 1'b1, 1'b1);
    issue(5'd4, 32'h0001_0000, 1'b0, 1'b1, 1'b1);
    drain();

    // Exception pass-through
    issue(5'd9, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
    idle(LAT);
    chk("exc_wb_exception", 32'(wb_exception), 32'd1);
    chk("exc_wb_tag", 32'(wb_tag), 32'd9);
    drain();

    // Full push+pop: 3 buffered, 4th arrives while head pops
    wb_ready = 1'b0;
    issue(5'd1, 32'd11, 1'b0, 1'b1, 1'b1);
    issue(5'd2, 32'd22, 1'b0, 1'b1, 1'b1);
    issue(5'd3, 32'd33, 1'b0, 1'b1, 1'b1);
    idle(1);
    issue(5'd4, 32'd44, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("full_rdy_aligned", 32'(mult_result_RDY), 32'd1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("full_head_after", 32'(wb_tag), 32'd2);
    chk("full_allowed_at3", 32'(issue_allowed), 32'd1);
    issue(5'd6, 32'd66, 1'b0, 1'b1, 1'b1);
    chk("full_allowed_at4", 32'(issue_allowed), 32'd0);
    drain();
    chk("full_no_overflow", 32'(err_overflow), 32'd0);

    // Backpressure: overflow issue and its orphan RDY
    wb_ready = 1'b0;
    issue(5'd1, 32'd100, 1'b0, 1'b1, 1'b1);
    issue(5'd2, 32'd200, 1'b0, 1'b1, 1'b1);
    issue(5'd3, 32'd300, 1'b0, 1'b1, 1'b1);
    issue(5'd4, 32'd400, 1'b0, 1'b1, 1'b1);
    chk("bp_allowed_low", 32'(issue_allowed), 32'd0);
    issue(5'd5, 32'd500, 1'b0, 1'b0, 1'b1);
    chk("bp_err_overflow", 32'(err_overflow), 32'd1);
    idle(5);
    chk("bp_err_orphan", 32'(err_orphan), 32'd1);
    chk("bp_hold_tag", 32'(wb_tag), 32'd1);
    chk("bp_hold_data", wb_data, 32'd100);
    idle(1);
    chk("bp_hold_tag2", 32'(wb_tag), 32'd1);
    chk("bp_still_low", 32'(issue_allowed), 32'd0);
    wb_ready = 1'b1;
    tick();
    chk("bp_allowed_back", 32'(issue_allowed), 32'd1);
    drain();

    // Reset mid-flight: stale results must not push nor flag orphans
    issue(5'd1, 32'd7, 1'b0, 1'b1, 1'b0);
    issue(5'd2, 32'd8, 1'b0, 1'b1, 1'b0);
    idle(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmf_err_cleared", 32'(err_overflow), 32'd0);
    idle(6);
    chk("rmf_wb_valid", 32'(wb_valid), 32'd0);
    chk("rmf_err_orphan", 32'(err_orphan), 32'd0);
    chk("rmf_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
